pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16: bits per input word, streamed MSB first.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-006 SHALL have port cfg_pattern, input, 8: target pattern, LSB = most recent bit.
REQ-007 SHALL have port cfg_len, input, 3: pattern length minus 1 (length 1..8).
REQ-008 SHALL have port cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port start, input, 1: begin a frame.
REQ-010 SHALL have port abort, input, 1: synchronous frame abort.
REQ-011 SHALL have port word_valid, input, 1: requester offers a word.
REQ-012 SHALL have port word_data, input, WORD_W: word to scan.
REQ-013 SHALL have port word_last, input, 1: qualifies word_data as last word of the frame.
REQ-014 SHALL have port word_ready, output, 1: block accepts a word this cycle.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port match_pulse, output, 1: one-cycle match indication.
REQ-017 SHALL have port match_count, output, CNT_W: matches in the current or last frame.
REQ-018 SHALL have port done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-019 SHALL implement states IDLE, SCAN, DONE: IDLE->SCAN on start; SCAN->DONE after the last bit of a word_last word is shifted; DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL latch cfg_pattern/cfg_len/cfg_overlap on cfg_we only in IDLE; cfg_we in SCAN or DONE is ignored.
REQ-021 On start in IDLE: SHALL clear match_count, the 8-bit history register, and the fill counter; start outside IDLE is ignored.
REQ-022 word_ready SHALL be high only in SCAN when no word is loaded (bits remaining = 0); transfer occurs on word_valid & word_ready.
REQ-023 After a transfer, SHALL shift exactly one bit per cycle, MSB first, over WORD_W cycles; word_ready stays low until the last bit has shifted (one idle cycle between back-to-back words).
REQ-024 Per shifted bit: history <= {history[6:0], bit}; fill counter increments, saturating at 8.
REQ-025 Match SHALL occur when fill (after the shift) >= cfg_len+1 and history[cfg_len:0] == cfg_pattern[cfg_len:0].
REQ-026 match_pulse SHALL be high for the one cycle following the edge that shifts in the completing bit; match_count increments on the same edge, saturating at 2^CNT_W-1.
REQ-027 Non-overlap mode: on a match, fill SHALL reset to 0 so bits of a matched window are never reused; overlap mode: fill unchanged.
REQ-028 History and fill SHALL persist across word boundaries within a frame.
REQ-029 done SHALL be high exactly during the DONE cycle; match_count holds its value until the next start.
REQ-030 abort in SCAN or DONE SHALL return to IDLE at the next edge, discard the loaded word, suppress done, and retain match_count; abort in IDLE has no effect.
REQ-031 abort takes priority over word transfer and over end-of-frame in the same cycle.

Reset
REQ-032 rst high SHALL immediately force IDLE and drive word_ready=0, busy=0, match_pulse=0, done=0, match_count=0, independent of clk.
REQ-033 Reset SHALL clear cfg_pattern=0, cfg_len=0, cfg_overlap=0, history=0, fill=0, and the bit counter; assertion mid-SCAN aborts the frame with no done.

Verification
REQ-034 cfg pattern 8'h0B, len 3, overlap 1; one word 16'b1011_1011_0101_1011 last -> match_pulse after bits 3, 7, 12, 15; match_count=4; done one cycle later.
REQ-035 Same word, overlap 0 -> matches after bits 3, 7, 12; match_count=3.
REQ-036 pattern 8'h03, len 1; word 16'hFFFF last -> overlap: count 15; non-overlap: count 8.
REQ-037 pattern 8'h03, len 1, overlap 1; 18 words 16'hFFFF, last on word 18 -> count saturates at 255 (unsaturated 287).
REQ-038 cfg_we with pattern 8'hFF during SCAN -> ignored, detection continues with the original pattern; rst asserted mid-SCAN -> all outputs 0 without a clock edge, and no done.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Purpose : serial pattern matcher; words are shifted MSB first, one bit per clk, into an 8-bit history.
// Latency : match_pulse/match_count update one edge after the completing bit shifts; done follows the last bit by one cycle.
// Backpressure: word_ready is high only in SCAN with no word loaded, so there is one idle cycle between back-to-back words.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   cfg_we, cfg_pattern, cfg_len,
//   cfg_overlap                      : pattern configuration, accepted only in IDLE
//   start, abort                     : frame start (IDLE only) / frame abort (SCAN or DONE)
//   word_valid, word_data, word_last,
//   word_ready                       : valid/ready word input, word_last marks the frame's final word
//   busy, match_pulse, match_count,
//   done                             : status and results
module pattern_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_pattern,
  input  logic [2:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int BR_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [7:0]        pat_q;
  logic [2:0]        len_q;
  logic              ovl_q;
  logic [7:0]        hist;
  logic [3:0]        fill;
  logic [WORD_W-1:0] shreg;
  logic [BR_W-1:0]   bits_rem;
  // Set when the loaded word is the frame's last one; holds word_ready low
  // until the frame closes so no word from the next frame sneaks in.
  logic              last_q;

  logic [7:0]        hist_nxt;
  logic [3:0]        fill_nxt;
  logic [3:0]        len_p1;
  logic [7:0]        len_mask;
  logic              hit;

  always_comb begin
    hist_nxt = {hist[6:0], shreg[WORD_W-1]};
    fill_nxt = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
    len_p1   = {1'b0, len_q} + 4'd1;
    len_mask = 8'hFF >> (3'd7 - len_q);
    // Require enough fresh bits so a non-overlap restart cannot reuse old ones.
    hit      = (fill_nxt >= len_p1) && (((hist_nxt ^ pat_q) & len_mask) == 8'h00);
  end

  assign word_ready = (state == SCAN) && (bits_rem == '0) && !last_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= 8'h00;
      len_q       <= 3'd0;
      ovl_q       <= 1'b0;
      hist        <= 8'h00;
      fill        <= 4'd0;
      shreg       <= '0;
      bits_rem    <= '0;
      last_q      <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
          end
          if (start) begin
            state       <= SCAN;
            match_count <= '0;
            hist        <= 8'h00;
            fill        <= 4'd0;
            bits_rem    <= '0;
            last_q      <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            state    <= IDLE;
            bits_rem <= '0;
            last_q   <= 1'b0;
          end else if (bits_rem != '0) begin
            shreg    <= shreg << 1;
            bits_rem <= bits_rem - BR_W'(1);
            hist     <= hist_nxt;
            fill     <= (hit && !ovl_q) ? 4'd0 : fill_nxt;
            if (hit) begin
              match_pulse <= 1'b1;
              if (match_count != CNT_MAX) begin
                match_count <= match_count + CNT_W'(1);
              end
            end
          end else if (last_q) begin
            state  <= DONE;
            last_q <= 1'b0;
          end else if (word_valid) begin
            shreg    <= word_data;
            bits_rem <= BR_W'(WORD_W);
            last_q   <= word_last;
          end
        end
        DONE: begin
          // Abort here lands in IDLE as well; done is visible only this cycle.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Purpose : self-checking bench for pattern_scan_ctrl with a bit-list reference model.
// Latency : observes outputs on the falling edge, drives inputs right after it.
// Backpressure: offers words only when word_ready is seen high, with random gaps.
module tb_pattern_scan_ctrl;

  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_pattern = 8'h00;
  logic [2:0]    cfg_len = 3'd0;
  logic          cfg_overlap = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic [W-1:0]  word_data = '0;
  logic          word_last = 1'b0;
  logic          word_ready;
  logic          busy;
  logic          match_pulse;
  logic [CW-1:0] match_count;
  logic          done;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count), .done(done)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] frame_q[$];
  int           gap_max = 0;
  bit           stray_start = 1'b0;
  int           inject_cfg_at = -1;

  logic [511:0] obs_map, exp_map;
  int           obs_count, exp_count, obs_done_bad, obs_ready_bad;
  bit           obs_timeout;

  logic [7:0]   mdl_pat = 8'h00;
  int           mdl_len = 0;
  bit           mdl_ovl = 1'b0;

  task automatic set_cfg(input logic [7:0] p, input int l, input bit o);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = 3'(l); cfg_overlap = o;
    @(negedge clk);
    cfg_we = 1'b0;
    mdl_pat = p; mdl_len = l; mdl_ovl = o;
  endtask

  // Reference: the frame is a flat list of bits; a match is the last L bits
  // equalling the pattern with at least L bits collected since the last reuse cut.
  task automatic model_frame;
    int win, win_len, L, gi;
    logic [W-1:0] wd;
    exp_map = '0; exp_count = 0; win = 0; win_len = 0; gi = 0;
    L = mdl_len + 1;
    foreach (frame_q[w]) begin
      wd = frame_q[w];
      for (int i = W - 1; i >= 0; i--) begin
        win = ((win << 1) | int'(wd[i])) & 'hFF;
        win_len++;
        if (win_len >= L && (((win ^ int'(mdl_pat)) & ((1 << L) - 1)) == 0)) begin
          exp_map[gi] = 1'b1;
          if (exp_count < CMAX) exp_count++;
          if (!mdl_ovl) win_len = 0;
        end
        gi++;
      end
    end
  endtask

  // Drives one frame from frame_q and records what the DUT did.
  task automatic run_frame;
    int it, t, cur, nxt, gap, done_exp, bi;
    obs_map = '0; obs_count = 0; obs_done_bad = 0; obs_ready_bad = 0; obs_timeout = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    it = 1; t = -1000; cur = 0; nxt = 0; done_exp = -1;
    gap = $urandom_range(0, gap_max);
    forever begin
      if (match_pulse === 1'b1) begin
        bi = cur * W + (it - t - 2);
        if (bi < 0 || bi >= 512) obs_done_bad++;
        else obs_map[bi] = 1'b1;
      end
      if (word_ready !== ((nxt < frame_q.size()) && (it >= t + W + 1))) obs_ready_bad++;
      if (it == done_exp) begin
        if (done !== 1'b1) obs_done_bad++;
        obs_count = int'(match_count);
        break;
      end
      if (done !== 1'b0) obs_done_bad++;
      cfg_we = (it == inject_cfg_at);
      cfg_pattern = 8'hFF; cfg_len = 3'd7; cfg_overlap = ~mdl_ovl;
      start = stray_start && ($urandom_range(0, 3) == 0);
      word_valid = 1'b0; word_last = 1'b0;
      if (nxt < frame_q.size()) begin
        word_data = frame_q[nxt];
        if (word_ready === 1'b1) begin
          if (gap > 0) gap--;
          else begin
            word_valid = 1'b1;
            word_last = (nxt == frame_q.size() - 1);
            t = it; cur = nxt; nxt++;
            if (word_last) done_exp = it + W + 2;
            gap = $urandom_range(0, gap_max);
          end
        end else begin
          word_valid = 1'($urandom_range(0, 1));
        end
      end else begin
        word_data = '0;
      end
      @(negedge clk);
      it++;
      if (it > 3000) begin obs_timeout = 1'b1; break; end
    end
    cfg_we = 1'b0; start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) obs_done_bad++;
    if (match_count !== CW'(obs_count)) obs_done_bad++;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, word_ready, done, match_pulse, match_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b done=%b pulse=%b cnt=%0d expected all 0",
               busy, word_ready, done, match_pulse, match_count);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, word_ready, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b rdy=%b done=%b expected 000", busy, word_ready, done);
    end
  endtask

  task automatic test_vector(input bit ovl);
    set_cfg(8'h0B, 3, ovl);
    frame_q.delete(); frame_q.push_back(16'hBB5B);
    gap_max = 0;
    run_frame();
    exp_map = '0; exp_map[3] = 1'b1; exp_map[7] = 1'b1; exp_map[12] = 1'b1;
    if (ovl) exp_map[15] = 1'b1;
    exp_count = ovl ? 4 : 3;
    checks++;
    if (obs_map !== exp_map) begin errors++; $display("FAIL vector_pulses ovl=%0b: got %h expected %h", ovl, obs_map, exp_map); end
    checks++;
    if (obs_count != exp_count) begin errors++; $display("FAIL vector_count ovl=%0b: got %0d expected %0d", ovl, obs_count, exp_count); end
    checks++;
    if (obs_done_bad != 0 || obs_ready_bad != 0 || obs_timeout) begin
      errors++; $display("FAIL vector_protocol ovl=%0b: done_bad=%0d ready_bad=%0d timeout=%0b expected 0", ovl, obs_done_bad, obs_ready_bad, obs_timeout);
    end
  endtask

  task automatic test_all_ones;
    for (int o = 0; o < 2; o++) begin
      set_cfg(8'h03, 1, o[0]);
      frame_q.delete(); frame_q.push_back(16'hFFFF);
      gap_max = 2;
      run_frame();
      model_frame();
      checks++;
      if (obs_count != (o ? 15 : 8)) begin errors++; $display("FAIL ones_count ovl=%0d: got %0d expected %0d", o, obs_count, o ? 15 : 8); end
      checks++;
      if (obs_map !== exp_map || obs_done_bad != 0 || obs_ready_bad != 0 || obs_timeout) begin
        errors++; $display("FAIL ones_pulses ovl=%0d: got %h bad=%0d/%0d expected %h", o, obs_map, obs_done_bad, obs_ready_bad, exp_map);
      end
    end
  endtask

  task automatic test_saturation;
    set_cfg(8'h03, 1, 1'b1);
    frame_q.delete();
    for (int i = 0; i < 18; i++) frame_q.push_back(16'hFFFF);
    gap_max = 1;
    run_frame();
    model_frame();
    checks++;
    if (obs_count != 255) begin errors++; $display("FAIL sat_count: got %0d expected 255", obs_count); end
    checks++;
    if (obs_map !== exp_map || obs_done_bad != 0 || obs_ready_bad != 0 || obs_timeout) begin
      errors++; $display("FAIL sat_pulses: got %h bad=%0d/%0d expected %h", obs_map, obs_done_bad, obs_ready_bad, exp_map);
    end
  endtask

  task automatic test_cfg_ignored;
    set_cfg(8'h0B, 3, 1'b1);
    frame_q.delete(); frame_q.push_back(16'hBB5B);
    gap_max = 0; inject_cfg_at = 5;
    run_frame();
    inject_cfg_at = -1;
    exp_map = '0; exp_map[3] = 1'b1; exp_map[7] = 1'b1; exp_map[12] = 1'b1; exp_map[15] = 1'b1;
    checks++;
    if (obs_map !== exp_map || obs_count != 4) begin
      errors++; $display("FAIL cfg_ignored: got %h cnt=%0d expected %h cnt=4", obs_map, obs_count, exp_map);
    end
  endtask

  task automatic test_back_to_back;
    set_cfg(8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    frame_q.delete();
    for (int i = 0; i < 3; i++) frame_q.push_back(W'($urandom));
    gap_max = 0;
    run_frame();
    model_frame();
    checks++;
    if (obs_map !== exp_map || obs_count != exp_count) begin
      errors++; $display("FAIL b2b_result: got %h cnt=%0d expected %h cnt=%0d", obs_map, obs_count, exp_map, exp_count);
    end
    checks++;
    if (obs_done_bad != 0 || obs_ready_bad != 0 || obs_timeout) begin
      errors++; $display("FAIL b2b_protocol: done_bad=%0d ready_bad=%0d timeout=%0b expected 0", obs_done_bad, obs_ready_bad, obs_timeout);
    end
  endtask

  task automatic test_random;
    int nw;
    for (int f = 0; f < 12; f++) begin
      set_cfg(8'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      frame_q.delete();
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) frame_q.push_back(W'($urandom));
      gap_max = 3; stray_start = 1'b1;
      run_frame();
      stray_start = 1'b0;
      model_frame();
      checks++;
      if (obs_map !== exp_map || obs_count != exp_count || obs_done_bad != 0 || obs_ready_bad != 0 || obs_timeout) begin
        errors++;
        $display("FAIL random_frame%0d: got %h cnt=%0d bad=%0d/%0d/%0b expected %h cnt=%0d",
                 f, obs_map, obs_count, obs_done_bad, obs_ready_bad, obs_timeout, exp_map, exp_count);
      end
    end
  endtask

  task automatic test_abort;
    int bad;
    set_cfg(8'h03, 1, 1'b1);
    // Abort mid-word: six bits shifted, so five overlapping matches are kept.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    word_valid = 1'b1; word_data = 16'hFFFF; word_last = 1'b0;
    @(negedge clk); word_valid = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || word_ready !== 1'b0 || match_count !== 8'd5) begin
      errors++; $display("FAIL abort_mid: got busy=%b rdy=%b cnt=%0d expected 0 0 5", busy, word_ready, match_count);
    end
    bad = 0;
    repeat (20) begin @(negedge clk); if (done !== 1'b0 || match_pulse !== 1'b0 || match_count !== 8'd5) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
    // Abort in the same cycle as a word offer wins over the transfer.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    word_valid = 1'b1; word_data = 16'hFFFF; word_last = 1'b1; abort = 1'b1;
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0; abort = 1'b0;
    bad = 0;
    repeat (20) begin @(negedge clk); if (busy !== 1'b0 || done !== 1'b0 || match_pulse !== 1'b0) bad++; end
    checks++;
    if (bad != 0 || match_count !== 8'd0) begin
      errors++; $display("FAIL abort_vs_transfer: got bad=%0d cnt=%0d expected 0 0", bad, match_count);
    end
    // Abort on the cycle the frame would close suppresses done.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    word_valid = 1'b1; word_data = 16'hFFFF; word_last = 1'b1;
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    repeat (W) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || match_count !== 8'd15) begin
      errors++; $display("FAIL abort_vs_end: got done=%b busy=%b cnt=%0d expected 0 0 15", done, busy, match_count);
    end
    // Abort in IDLE changes nothing.
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd15) begin
      errors++; $display("FAIL abort_idle: got busy=%b done=%b cnt=%0d expected 0 0 15", busy, done, match_count);
    end
  endtask

  task automatic test_rst_mid_scan;
    int bad;
    set_cfg(8'h0B, 3, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    word_valid = 1'b1; word_data = 16'hBB5B; word_last = 1'b1;
    @(negedge clk); word_valid = 1'b0; word_last = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, word_ready, done, match_pulse, match_count} !== '0) begin
      errors++;
      $display("FAIL rst_async: got busy=%b rdy=%b done=%b pulse=%b cnt=%0d expected all 0",
               busy, word_ready, done, match_pulse, match_count);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) bad++; end
    rst = 1'b0;
    repeat (20) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0 || match_count !== 8'd0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_done: got %0d bad cycles expected 0", bad); end
    // Configuration was cleared: pattern 0, length 1, non-overlap hits every zero bit.
    mdl_pat = 8'h00; mdl_len = 0; mdl_ovl = 1'b0;
    frame_q.delete(); frame_q.push_back(16'h00F0);
    gap_max = 0;
    run_frame();
    model_frame();
    checks++;
    if (obs_count != 12 || obs_map !== exp_map) begin
      errors++; $display("FAIL rst_cfg_cleared: got %h cnt=%0d expected %h cnt=12", obs_map, obs_count, exp_map);
    end
  endtask

  initial begin
    test_reset();
    test_vector(1'b1);
    test_vector(1'b0);
    test_all_ones();
    test_saturation();
    test_cfg_ignored();
    test_back_to_back();
    test_random();
    test_abort();
    test_rst_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
